mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
//------------------------------------------------------------------------------
// mc_ctrl : multi-cycle MIPS-subset control FSM (fetch/decode/exec/mem/wb).
// Optional: define MC_CTRL_XOR_EN to accept R-type funct 100110 as XOR.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mc_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [2:0]  alu_op,
   output logic        alu_src_a,
   output logic [2:0]  alu_src_b,
   output logic        pc_write,
   output logic        ir_write,
   output logic        tgt_write,
   output logic        reg_write,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  pc_src,
   output logic        reg_dst,
   output logic        wb_sel,
   output logic [3:0]  state,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC_R  = 4'd2,
      S_EXEC_I  = 4'd3,
      S_ADDR    = 4'd4,
      S_MEM_RD  = 4'd5,
      S_MEM_WR  = 4'd6,
      S_WB_MEM  = 4'd7,
      S_WB_R    = 4'd8,
      S_WB_I    = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   localparam logic [2:0] C_OP_ADDU = 3'b000;
   localparam logic [2:0] C_OP_SUBU = 3'b001;
   localparam logic [2:0] C_OP_AND  = 3'b010;
   localparam logic [2:0] C_OP_OR   = 3'b011;
   localparam logic [2:0] C_OP_LUI  = 3'b100;
`ifdef MC_CTRL_XOR_EN
   localparam logic [2:0] C_OP_XOR  = 3'b101;
`endif

   state_t      r_state;
   logic        r_illegal;
   logic [2:0]  r_op;
   logic        r_store;

   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;
   logic        w_r_legal;
   logic [2:0]  w_r_op;
   state_t      w_dec_next;
   logic [2:0]  w_dec_op;
   logic        w_unused;

   assign w_opcode = instr[31:26];
   assign w_funct  = instr[5:0];
   assign w_unused = ^instr[25:6];

   always_comb begin
      w_r_legal = 1'b1;
      w_r_op    = C_OP_ADDU;
      case (w_funct)
         6'b100001: w_r_op = C_OP_ADDU;
         6'b100011: w_r_op = C_OP_SUBU;
         6'b100100: w_r_op = C_OP_AND;
         6'b100101: w_r_op = C_OP_OR;
`ifdef MC_CTRL_XOR_EN
         6'b100110: w_r_op = C_OP_XOR;
`endif
         default:   w_r_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_dec_next = S_ILLEGAL;
      w_dec_op   = C_OP_ADDU;
      case (w_opcode)
         6'b000000: begin
            w_dec_next = w_r_legal ? S_EXEC_R : S_ILLEGAL;
            w_dec_op   = w_r_op;
         end
         6'b001101: begin
            w_dec_next = S_EXEC_I;
            w_dec_op   = C_OP_OR;
         end
         6'b001111: begin
            w_dec_next = S_EXEC_I;
            w_dec_op   = C_OP_LUI;
         end
         6'b100011, 6'b101011: w_dec_next = S_ADDR;
         6'b000100:            w_dec_next = S_BRANCH;
         6'b000010:            w_dec_next = S_JUMP;
         default:              w_dec_next = S_ILLEGAL;
      endcase
   end

   // The ALU op is captured at decode so later states never look at instr.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_op      <= C_OP_ADDU;
         r_store   <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH:   if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               r_state <= w_dec_next;
               r_op    <= w_dec_op;
               r_store <= (w_opcode == 6'b101011);
               if (w_dec_next == S_ILLEGAL) r_illegal <= 1'b1;
            end
            S_EXEC_R:  r_state <= S_WB_R;
            S_EXEC_I:  r_state <= S_WB_I;
            S_ADDR:    r_state <= r_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) r_state <= S_WB_MEM;
            S_MEM_WR:  if (mem_ready) r_state <= S_FETCH;
            S_WB_MEM,
            S_WB_R,
            S_WB_I,
            S_BRANCH,
            S_JUMP:    r_state <= S_FETCH;
            S_ILLEGAL: r_state <= S_ILLEGAL;
            default:   r_state <= S_FETCH;
         endcase
      end
   end

   logic w_pc_write, w_ir_write, w_tgt_write, w_reg_write, w_mem_req, w_mem_we;

   // Outputs are decoded from the state register; fetch completion and the
   // branch decision must react to mem_ready/zero in the same cycle.
   always_comb begin
      alu_op      = C_OP_ADDU;
      alu_src_a   = 1'b0;
      alu_src_b   = 3'd0;
      pc_src      = 2'd0;
      reg_dst     = 1'b0;
      wb_sel      = 1'b0;
      w_pc_write  = 1'b0;
      w_ir_write  = 1'b0;
      w_tgt_write = 1'b0;
      w_reg_write = 1'b0;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req  = 1'b1;
            alu_src_b  = 3'd1;
            w_ir_write = mem_ready;
            w_pc_write = mem_ready;
         end
         S_DECODE: begin
            alu_src_b   = 3'd4;
            w_tgt_write = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = r_op;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 3'd2;
            alu_op    = r_op;
         end
         S_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 3'd3;
         end
         S_MEM_RD:  w_mem_req = 1'b1;
         S_MEM_WR: begin
            w_mem_req = 1'b1;
            w_mem_we  = 1'b1;
         end
         S_WB_MEM: begin
            w_reg_write = 1'b1;
            wb_sel      = 1'b1;
         end
         S_WB_R: begin
            w_reg_write = 1'b1;
            reg_dst     = 1'b1;
         end
         S_WB_I: begin
            w_reg_write = 1'b1;
            alu_src_b   = 3'd2;
            alu_op      = r_op;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = C_OP_SUBU;
            pc_src     = 2'd1;
            w_pc_write = zero;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            pc_src     = 2'd2;
         end
         default: ;
      endcase
   end

   assign pc_write  = reset_n & w_pc_write;
   assign ir_write  = reset_n & w_ir_write;
   assign tgt_write = reset_n & w_tgt_write;
   assign reg_write = reset_n & w_reg_write;
   assign mem_req   = reset_n & w_mem_req;
   assign mem_we    = reset_n & w_mem_we;
   assign state     = r_state;
   assign illegal   = r_illegal;

endmodule

`default_nettype wire
